// File: rtl/bypass_rf_if.sv
`default_nettype none
// ============================================================================
// Module      : bypass_rf_if
// Description : Bundles the read, write and reservation signals of bypass_rf.
//               The master side (issue/producer logic) drives addresses, write
//               data and reservation requests. The slave side (the register
//               file) returns read data, busy flags, the reservation grant and
//               the pending-entry count.
// Ports       : src[read_ports]        read addresses            (master->slave)
//               dataout[read_ports]    read data                 (slave->master)
//               busy[read_ports]       source entry pending      (slave->master)
//               dst[write_ports]       write addresses           (master->slave)
//               datain[write_ports]    write data                (master->slave)
//               wr_en[write_ports]     per-port write enable     (master->slave)
//               rsv_en / rsv_dst       reservation request       (master->slave)
//               rsv_grant              reservation accepted      (slave->master)
//               pending_count          number of pending entries (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface bypass_rf_if #(
   parameter int entries       = 8,
   parameter int data_bus_size = 8,
   parameter int read_ports    = 2,
   parameter int write_ports   = 2
);
   localparam int c_addr_w = $clog2(entries);
   localparam int c_cnt_w  = $clog2(entries + 1);

   logic [read_ports-1:0][c_addr_w-1:0]       src;
   logic [read_ports-1:0][data_bus_size-1:0]  dataout;
   logic [read_ports-1:0]                     busy;
   logic [write_ports-1:0][c_addr_w-1:0]      dst;
   logic [write_ports-1:0][data_bus_size-1:0] datain;
   logic [write_ports-1:0]                    wr_en;
   logic                                      rsv_en;
   logic [c_addr_w-1:0]                       rsv_dst;
   logic                                      rsv_grant;
   logic [c_cnt_w-1:0]                        pending_count;

   modport master (
      output src, dst, datain, wr_en, rsv_en, rsv_dst,
      input  dataout, busy, rsv_grant, pending_count
   );

   modport slave (
      input  src, dst, datain, wr_en, rsv_en, rsv_dst,
      output dataout, busy, rsv_grant, pending_count
   );
endinterface
`default_nettype wire

// File: rtl/bypass_rf.sv
`default_nettype none
// ============================================================================
// Module      : bypass_rf
// Description : Multi-ported register file with optional same-cycle
//               write-to-read forwarding, an optional hardwired zero entry and
//               a per-entry "pending" scoreboard. A producer reserves an entry
//               (marking it pending); a later write to that entry delivers the
//               data and clears the pending bit. Readers see busy=1 while the
//               entry they address is still waiting for its producer.
// Ports       : clock  - rising-edge clock for all state
//               reset  - synchronous, active-high reset
//               bus    - bypass_rf_if.slave (read, write, reservation ports)
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_rf #(
   parameter int entries       = 8,
   parameter int data_bus_size = 8,
   parameter int read_ports    = 2,
   parameter int write_ports   = 2,
   parameter int bypass        = 1,
   parameter int zero_reg      = 1
) (
   input  wire logic  clock,
   input  wire logic  reset,
   bypass_rf_if.slave bus
);
   localparam int c_addr_w = $clog2(entries);
   localparam int c_cnt_w  = $clog2(entries + 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [data_bus_size-1:0] r_mem [entries];
   logic [entries-1:0]       r_pending;
   logic [c_cnt_w-1:0]       r_pending_count;

   // ------------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------------
   logic [entries-1:0]                        w_wr_hit;
   logic [data_bus_size-1:0]                  w_wr_data [entries];
   logic                                      w_rsv_grant;
   logic [entries-1:0]                        w_pending_nxt;
   logic [c_cnt_w-1:0]                        w_count_nxt;
   logic [read_ports-1:0][data_bus_size-1:0]  w_rd_data;
   logic [read_ports-1:0]                     w_rd_busy;

   // ------------------------------------------------------------------------
   // Write merge: ports are scanned in ascending order so that, when several
   // ports target the same entry, the highest-index port's data is the one
   // left in w_wr_data. Reset and the zero entry suppress the commit.
   // ------------------------------------------------------------------------
   always_comb begin
      w_wr_hit = '0;
      for (int e = 0; e < entries; e++) begin
         w_wr_data[e] = r_mem[e];
      end
      for (int j = 0; j < write_ports; j++) begin
         if (bus.wr_en[j] && !reset) begin
            w_wr_hit[bus.dst[j]]  = 1'b1;
            w_wr_data[bus.dst[j]] = bus.datain[j];
         end
      end
      if (zero_reg != 0) begin
         w_wr_hit[0] = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Reservation: refused while reset is high, when the entry already has an
   // outstanding producer (WAW stall), or when it targets the zero entry.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rsv_grant = bus.rsv_en && !reset && !r_pending[bus.rsv_dst];
      if ((zero_reg != 0) && (bus.rsv_dst == '0)) begin
         w_rsv_grant = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Next pending vector. A committed write clears its entry, a granted
   // reservation sets its entry; the reservation is applied last so that a
   // same-cycle write plus reservation leaves the entry pending for the new
   // producer. The count is the population of the next vector, so it always
   // tracks the bits exactly and cannot wrap.
   // ------------------------------------------------------------------------
   always_comb begin
      w_count_nxt = '0;
      for (int e = 0; e < entries; e++) begin
         w_pending_nxt[e] = r_pending[e] && !w_wr_hit[e];
         if (w_rsv_grant && (bus.rsv_dst == c_addr_w'(e))) begin
            w_pending_nxt[e] = 1'b1;
         end
      end
      if (zero_reg != 0) begin
         w_pending_nxt[0] = 1'b0;
      end
      for (int e = 0; e < entries; e++) begin
         w_count_nxt = w_count_nxt + c_cnt_w'(w_pending_nxt[e]);
      end
   end

   // ------------------------------------------------------------------------
   // State update
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int e = 0; e < entries; e++) begin
            r_mem[e] <= '0;
         end
         r_pending       <= '0;
         r_pending_count <= '0;
      end else begin
         for (int e = 0; e < entries; e++) begin
            if (w_wr_hit[e]) begin
               r_mem[e] <= w_wr_data[e];
            end
         end
         r_pending       <= w_pending_nxt;
         r_pending_count <= w_count_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports. With forwarding enabled, a same-cycle write to the source
   // entry supplies the data directly (highest-index writer wins) and hides
   // the pending bit, since the producer is delivering right now. Forwarding
   // is disabled while reset is high because that write will not commit.
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < read_ports; i++) begin
         w_rd_data[i] = r_mem[bus.src[i]];
         w_rd_busy[i] = r_pending[bus.src[i]];
         if ((bypass != 0) && !reset) begin
            for (int j = 0; j < write_ports; j++) begin
               if (bus.wr_en[j] && (bus.dst[j] == bus.src[i])) begin
                  w_rd_data[i] = bus.datain[j];
                  w_rd_busy[i] = 1'b0;
               end
            end
         end
         if ((zero_reg != 0) && (bus.src[i] == '0)) begin
            w_rd_data[i] = '0;
            w_rd_busy[i] = 1'b0;
         end
      end
   end

   assign bus.dataout       = w_rd_data;
   assign bus.busy          = w_rd_busy;
   assign bus.rsv_grant     = w_rsv_grant;
   assign bus.pending_count = r_pending_count;

endmodule
`default_nettype wire

// File: tb/tb_bypass_rf.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_rf
// Description : Self-checking bench for bypass_rf. Directed scenarios followed
//               by randomized traffic, compared against an array/scoreboard
//               model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_rf;
   localparam int c_entries = 8;
   localparam int c_dw      = 8;
   localparam int c_rp      = 2;
   localparam int c_wp      = 2;
   localparam int c_aw      = 3;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   bypass_rf_if #(
      .entries       (c_entries),
      .data_bus_size (c_dw),
      .read_ports    (c_rp),
      .write_ports   (c_wp)
   ) bus ();

   bypass_rf #(
      .entries       (c_entries),
      .data_bus_size (c_dw),
      .read_ports    (c_rp),
      .write_ports   (c_wp),
      .bypass        (1),
      .zero_reg      (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: contents and pending flags of every entry.
   logic [c_dw-1:0] m_mem  [c_entries];
   bit              m_pend [c_entries];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int e = 0; e < c_entries; e++) n += int'(m_pend[e]);
      return n;
   endfunction

   function automatic bit model_grant();
      return bus.rsv_en && !reset && !m_pend[bus.rsv_dst] && (bus.rsv_dst != 0);
   endfunction

   task automatic model_clear();
      for (int e = 0; e < c_entries; e++) begin
         m_mem[e]  = '0;
         m_pend[e] = 1'b0;
      end
   endtask

   // Quiet cycle: no writes, no reservation, random addresses and data.
   task automatic idle();
      reset       = 1'b0;
      bus.wr_en   = '0;
      bus.rsv_en  = 1'b0;
      bus.rsv_dst = c_aw'($urandom_range(0, c_entries - 1));
      for (int i = 0; i < c_rp; i++) bus.src[i] = c_aw'($urandom_range(0, c_entries - 1));
      for (int j = 0; j < c_wp; j++) begin
         bus.dst[j]    = c_aw'($urandom_range(0, c_entries - 1));
         bus.datain[j] = c_dw'($urandom);
      end
   endtask

   // Checks all outputs against the model for the inputs currently driven,
   // then advances the model across the next rising edge.
   task automatic apply();
      logic [c_wp-1:0]           s_wr_en;
      logic [c_wp-1:0][c_aw-1:0] s_dst;
      logic [c_wp-1:0][c_dw-1:0] s_datain;
      logic [c_aw-1:0]           s_rsv_dst;
      logic                      s_reset;
      bit                        s_grant;
      #1;
      for (int i = 0; i < c_rp; i++) begin
         logic [c_aw-1:0] s;
         logic [c_dw-1:0] ed;
         bit              eb;
         s  = bus.src[i];
         ed = m_mem[s];
         eb = m_pend[s];
         if (!reset) begin
            for (int j = 0; j < c_wp; j++) begin
               if (bus.wr_en[j] && bus.dst[j] == s) begin
                  ed = bus.datain[j];
                  eb = 1'b0;
               end
            end
         end
         if (s == 0) begin
            ed = '0;
            eb = 1'b0;
         end
         check_val($sformatf("dataout[%0d] src=%0d", i, s), 32'(bus.dataout[i]), 32'(ed));
         check_val($sformatf("busy[%0d] src=%0d", i, s), 32'(bus.busy[i]), 32'(eb));
      end
      s_grant = model_grant();
      check_val("rsv_grant", 32'(bus.rsv_grant), 32'(s_grant));
      check_val("pending_count", 32'(bus.pending_count), 32'(model_count()));
      s_wr_en   = bus.wr_en;
      s_dst     = bus.dst;
      s_datain  = bus.datain;
      s_rsv_dst = bus.rsv_dst;
      s_reset   = reset;
      @(posedge clock);
      if (s_reset) begin
         model_clear();
      end else begin
         for (int j = 0; j < c_wp; j++) begin
            if (s_wr_en[j] && s_dst[j] != 0) begin
               m_mem[s_dst[j]]  = s_datain[j];
               m_pend[s_dst[j]] = 1'b0;
            end
         end
         if (s_grant) m_pend[s_rsv_dst] = 1'b1;
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clock);
      model_clear();

      // Write 0xA5 to entry 3 on port 0, read it back next cycle.
      @(negedge clock); idle();
      bus.wr_en[0] = 1'b1; bus.dst[0] = 3'd3; bus.datain[0] = 8'hA5;
      apply();
      @(negedge clock); idle();
      bus.src[0] = 3'd3;
      #1;
      check_val("read3_data", 32'(bus.dataout[0]), 32'h0000_00A5);
      check_val("read3_busy", 32'(bus.busy[0]), 32'h0);
      apply();

      // Two ports write entry 5: the higher-index port wins, forwarded and stored.
      @(negedge clock); idle();
      bus.wr_en = 2'b11;
      bus.dst[0] = 3'd5; bus.datain[0] = 8'h11;
      bus.dst[1] = 3'd5; bus.datain[1] = 8'h22;
      bus.src[0] = 3'd5;
      #1;
      check_val("bypass5", 32'(bus.dataout[0]), 32'h22);
      apply();
      @(negedge clock); idle();
      bus.src[0] = 3'd5;
      #1;
      check_val("mem5", 32'(bus.dataout[0]), 32'h22);
      apply();

      // Reserve entry 2, re-reserve (stall), then write it.
      @(negedge clock); idle();
      bus.rsv_en = 1'b1; bus.rsv_dst = 3'd2;
      #1;
      check_val("rsv2_grant", 32'(bus.rsv_grant), 32'h1);
      apply();
      @(negedge clock); idle();
      bus.rsv_en = 1'b1; bus.rsv_dst = 3'd2; bus.src[0] = 3'd2;
      #1;
      check_val("rsv2_again_grant", 32'(bus.rsv_grant), 32'h0);
      check_val("rsv2_busy", 32'(bus.busy[0]), 32'h1);
      check_val("rsv2_count", 32'(bus.pending_count), 32'h1);
      apply();
      @(negedge clock); idle();
      bus.wr_en[1] = 1'b1; bus.dst[1] = 3'd2; bus.datain[1] = 8'h5A;
      apply();
      @(negedge clock); idle();
      bus.src[0] = 3'd2;
      #1;
      check_val("wr2_busy", 32'(bus.busy[0]), 32'h0);
      check_val("wr2_count", 32'(bus.pending_count), 32'h0);
      apply();

      // Write and reserve entry 4 together: data lands and entry stays pending.
      @(negedge clock); idle();
      bus.wr_en[0] = 1'b1; bus.dst[0] = 3'd4; bus.datain[0] = 8'h3C;
      bus.rsv_en = 1'b1; bus.rsv_dst = 3'd4;
      apply();
      @(negedge clock); idle();
      bus.src[0] = 3'd4;
      #1;
      check_val("wr_rsv4_data", 32'(bus.dataout[0]), 32'h3C);
      check_val("wr_rsv4_busy", 32'(bus.busy[0]), 32'h1);
      check_val("wr_rsv4_count", 32'(bus.pending_count), 32'h1);
      apply();
      @(negedge clock); idle();
      bus.wr_en[0] = 1'b1; bus.dst[0] = 3'd4; bus.datain[0] = 8'h3D;
      apply();

      // Entry 0 ignores writes and reservations.
      @(negedge clock); idle();
      bus.wr_en[0] = 1'b1; bus.dst[0] = 3'd0; bus.datain[0] = 8'hFF;
      bus.rsv_en = 1'b1; bus.rsv_dst = 3'd0; bus.src[0] = 3'd0;
      #1;
      check_val("zero_bypass", 32'(bus.dataout[0]), 32'h0);
      check_val("zero_grant", 32'(bus.rsv_grant), 32'h0);
      apply();
      @(negedge clock); idle();
      bus.src[0] = 3'd0;
      #1;
      check_val("zero_read", 32'(bus.dataout[0]), 32'h0);
      check_val("zero_count", 32'(bus.pending_count), 32'h0);
      apply();

      // Fill pending 1..7, then reset with a concurrent write.
      for (int e = 1; e < c_entries; e++) begin
         @(negedge clock); idle();
         bus.rsv_en = 1'b1; bus.rsv_dst = c_aw'(e);
         apply();
      end
      @(negedge clock); idle();
      #1;
      check_val("full_count", 32'(bus.pending_count), 32'h7);
      apply();
      @(negedge clock); idle();
      reset = 1'b1;
      bus.wr_en[0] = 1'b1; bus.dst[0] = 3'd6; bus.datain[0] = 8'h77;
      bus.rsv_en = 1'b1; bus.rsv_dst = 3'd1;
      #1;
      check_val("reset_grant", 32'(bus.rsv_grant), 32'h0);
      apply();
      for (int k = 0; k < c_entries / 2; k++) begin
         @(negedge clock); idle();
         bus.src[0] = c_aw'(2 * k);
         bus.src[1] = c_aw'(2 * k + 1);
         #1;
         for (int i = 0; i < c_rp; i++) begin
            check_val($sformatf("post_reset_data[%0d]", i), 32'(bus.dataout[i]), 32'h0);
            check_val($sformatf("post_reset_busy[%0d]", i), 32'(bus.busy[i]), 32'h0);
         end
         check_val("post_reset_count", 32'(bus.pending_count), 32'h0);
         apply();
      end

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         @(negedge clock); idle();
         reset       = ($urandom_range(0, 59) == 0);
         bus.wr_en   = c_wp'($urandom_range(0, 3) & $urandom_range(0, 3));
         bus.rsv_en  = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1) bus.dst[1] = bus.dst[0];
         if ($urandom_range(0, 2) == 0) bus.src[0] = bus.dst[$urandom_range(0, 1)];
         if ($urandom_range(0, 3) == 0) bus.rsv_dst = bus.dst[0];
         apply();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/bypass_rf.md
BYPASS_RF -- requirements
Module: bypass_rf

Interface
REQ-001 SHALL have parameter entries, default 8, number of register entries (power of two, >=2).
REQ-002 SHALL have parameter data_bus_size, default 8, width of each entry.
REQ-003 SHALL have parameter read_ports, default 2, number of combinational read ports.
REQ-004 SHALL have parameter write_ports, default 2, number of write ports.
REQ-005 SHALL have parameter bypass, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have parameter zero_reg, default 1; 1 = entry 0 hardwired to zero.
REQ-007 SHALL use one clock with synchronous, active-high reset; clock and reset ports are as listed below.
REQ-008 clock  input  1  rising-edge clock for all state.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 src  input  [read_ports] x clog2(entries)  read addresses.
REQ-011 dataout  output  [read_ports] x data_bus_size  read data.
REQ-012 busy  output  [read_ports] x 1  source entry has a pending write.
REQ-013 dst  input  [write_ports] x clog2(entries)  write addresses.
REQ-014 datain  input  [write_ports] x data_bus_size  write data.
REQ-015 wr_en  input  [write_ports] x 1  write enable, per port.
REQ-016 rsv_en  input  1  request to reserve rsv_dst as pending.
REQ-017 rsv_dst  input  clog2(entries)  entry to reserve.
REQ-018 rsv_grant  output  1  reservation accepted this cycle.
REQ-019 pending_count  output  clog2(entries+1)  number of entries currently pending.

Function
REQ-020 Writes SHALL commit at the rising edge when wr_en[j]=1 and reset=0.
REQ-021 Two or more ports writing the same dst in one cycle: the highest-index port's data SHALL be stored.
REQ-022 dataout[i] SHALL be combinational: mem[src[i]], with zero latency.
REQ-023 bypass=1: dataout[i] SHALL equal datain[j] for the highest j with wr_en[j]=1 and dst[j]==src[i] in the same cycle.
REQ-024 zero_reg=1: writes and reservations to entry 0 SHALL be ignored, reads of entry 0 SHALL return 0, and busy SHALL be 0 for entry 0.
REQ-025 rsv_grant SHALL be combinational: rsv_en & ~reset & ~pending[rsv_dst] & ~(zero_reg & rsv_dst==0).
REQ-026 A granted reservation SHALL set pending[rsv_dst] at the next rising edge.
REQ-027 A committed write SHALL clear pending[dst[j]] at the rising edge.
REQ-028 A write and a granted reservation to the same entry in the same cycle: data SHALL be written and pending SHALL end set (new producer wins).
REQ-029 A reservation of an already-pending entry SHALL be refused (rsv_grant=0), with no state change (WAW stall).
REQ-030 busy[i] SHALL equal pending[src[i]]; bypass=1 SHALL force busy[i]=0 when a same-cycle write to src[i] occurs.
REQ-031 pending_count SHALL be a registered count equal to the population of pending after each edge, never exceeding entries-1 when zero_reg=1.
REQ-032 pending_count SHALL change by +1, -n or +1-n per edge, consistent with REQ-026..028; there SHALL be no wrap-around.

Reset
REQ-033 With reset=1 at a rising edge, all mem entries, all pending bits and pending_count SHALL become 0.
REQ-034 While reset=1, writes and reservations SHALL be ignored, rsv_grant SHALL be 0 and bypass forwarding SHALL be disabled.
REQ-035 Reset asserted mid-operation SHALL override same-cycle writes and reservations; the first post-reset cycle SHALL read all 0 with busy all 0.

Verification
REQ-036 Reset, then write 0xA5 to entry 3 on port 0; the next cycle read src=3 -> dataout=0xA5, busy=0.
REQ-037 Same cycle: port0 writes 0x11 and port1 writes 0x22 to entry 5 -> bypass read returns 0x22; after the edge mem[5]=0x22.
REQ-038 Reserve entry 2 -> rsv_grant=1, then busy=1 for src=2 and pending_count=1; reserve 2 again -> rsv_grant=0; write 2 -> busy=0 and count=0.
REQ-039 Same cycle: write entry 4 and reserve entry 4 -> mem[4] updated, pending[4]=1 and count=1.
REQ-040 zero_reg=1: write 0xFF to entry 0 and reserve entry 0 -> read 0 returns 0x00, rsv_grant=0 and count unchanged.
REQ-041 Fill pending for entries 1..7, then assert reset together with a write -> all mem 0, count=0 and busy=0.
